// File: rtl/sudoku_pkg.sv
// Shared constants, status codes and sequencer state encoding for the
// sudoku pass sequencer slice.
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int CELL_W = 4;
  localparam int GRID_W = CELLS * CELL_W;

  typedef enum logic [1:0] {
    ST_SOLVED     = 2'd0,
    ST_STALLED    = 2'd1,
    ST_PASS_LIMIT = 2'd2,
    ST_TIMEOUT    = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENG_RST = 3'd1,
    S_RUN     = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/sudoku_grid_full.sv
// Combinational check that every cell of a grid holds a non-zero digit.
module sudoku_grid_full
  import sudoku_pkg::*;
#(
  parameter int N_CELLS = CELLS
) (
  input  logic [0:N_CELLS*CELL_W-1] grid,
  output logic                      full
);

  logic [N_CELLS-1:0] cell_nz;

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    assign cell_nz[gi] = |grid[gi*CELL_W +: CELL_W];
  end

  assign full = &cell_nz;

endmodule

// File: rtl/sudoku_pass_sequencer.sv
// Runs a candidate-elimination engine pass after pass on one puzzle, feeding
// each result back, until solved, stalled, out of passes or timed out.
module sudoku_pass_sequencer
  import sudoku_pkg::*;
#(
  parameter int  CELLS          = 81,
  parameter int  MAX_PASSES     = 16,
  parameter int  TIMEOUT_CYCLES = 4096,
  parameter int  ENG_RST_CYCLES = 2,
  localparam int W              = 4 * CELLS,
  localparam int PW             = $clog2(MAX_PASSES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:W-1]  in_puzzle,
  output logic          eng_rst,
  output logic          eng_start,
  output logic [0:W-1]  eng_puzzle,
  input  logic          eng_completed,
  input  logic [0:W-1]  eng_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:W-1]  out_puzzle,
  output logic [1:0]    out_status,
  output logic [PW-1:0] out_passes
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(ENG_RST_CYCLES + 1);

  state_e        state_q, state_d;
  logic [0:W-1]  work_q, work_d;
  logic [0:W-1]  prev_q, prev_d;
  logic [PW-1:0] passes_q, passes_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          in_ready_q, in_ready_d;
  logic          eng_rst_q, eng_rst_d;
  logic          eng_start_q, eng_start_d;
  logic          out_valid_q, out_valid_d;
  logic [0:W-1]  out_puzzle_q, out_puzzle_d;
  status_e       out_status_q, out_status_d;
  logic [PW-1:0] out_passes_q, out_passes_d;
  logic          work_full;

  sudoku_grid_full #(.N_CELLS(CELLS)) u_full (
    .grid (work_q),
    .full (work_full)
  );

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    prev_d       = prev_q;
    passes_d     = passes_q;
    timer_d      = timer_q;
    rcnt_d       = rcnt_q;
    out_puzzle_d = out_puzzle_q;
    out_status_d = out_status_q;
    out_passes_d = out_passes_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d   = in_puzzle;
          prev_d   = in_puzzle;
          passes_d = '0;
          rcnt_d   = '0;
          state_d  = S_ENG_RST;
        end
      end
      S_ENG_RST: begin
        if (rcnt_q == RW'(ENG_RST_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_RUN: begin
        // A completion in the final timer cycle still counts as a good pass.
        if (eng_completed) begin
          work_d   = eng_result;
          passes_d = passes_q + PW'(1);
          state_d  = S_CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          out_puzzle_d = work_q;
          out_status_d = ST_TIMEOUT;
          out_passes_d = passes_q;
          state_d      = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (work_full || (work_q == prev_q) || (passes_q == PW'(MAX_PASSES))) begin
          out_puzzle_d = work_q;
          out_passes_d = passes_q;
          state_d      = S_DONE;
          if (work_full)             out_status_d = ST_SOLVED;
          else if (work_q == prev_q) out_status_d = ST_STALLED;
          else                       out_status_d = ST_PASS_LIMIT;
        end else begin
          prev_d  = work_q;
          rcnt_d  = '0;
          state_d = S_ENG_RST;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == S_IDLE);
    eng_rst_d   = (state_d != S_RUN);
    eng_start_d = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      work_q       <= '0;
      prev_q       <= '0;
      passes_q     <= '0;
      timer_q      <= '0;
      rcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      eng_rst_q    <= 1'b1;
      eng_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_puzzle_q <= '0;
      out_status_q <= ST_SOLVED;
      out_passes_q <= '0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      prev_q       <= prev_d;
      passes_q     <= passes_d;
      timer_q      <= timer_d;
      rcnt_q       <= rcnt_d;
      in_ready_q   <= in_ready_d;
      eng_rst_q    <= eng_rst_d;
      eng_start_q  <= eng_start_d;
      out_valid_q  <= out_valid_d;
      out_puzzle_q <= out_puzzle_d;
      out_status_q <= out_status_d;
      out_passes_q <= out_passes_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign eng_rst    = eng_rst_q;
  assign eng_start  = eng_start_q;
  assign eng_puzzle = work_q;
  assign out_valid  = out_valid_q;
  assign out_puzzle = out_puzzle_q;
  assign out_status = out_status_q;
  assign out_passes = out_passes_q;

endmodule

// File: tb/tb_sudoku_pass_sequencer.sv
// Self-checking bench: behavioural engine plus a pass-level reference model.
module tb_sudoku_pass_sequencer;
  import sudoku_pkg::*;

  localparam int W    = GRID_W;
  localparam int MAXP = 16;
  localparam int TMO  = 4096;
  localparam int ERC  = 2;
  localparam int LAT  = 20;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int M_FILL = 0, M_ECHO = 1, M_NEVER = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:W-1]  in_puzzle = '0;
  logic          eng_rst, eng_start;
  logic [0:W-1]  eng_puzzle;
  logic          eng_completed = 1'b0;
  logic [0:W-1]  eng_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [0:W-1]  out_puzzle;
  logic [1:0]    out_status;
  logic [PW-1:0] out_passes;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eng_mode = M_FILL;
  int eng_cnt = 0;
  int rst_run = 0;
  int starts = 0;
  int short_runs = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  sudoku_pass_sequencer #(
    .CELLS(81), .MAX_PASSES(MAXP), .TIMEOUT_CYCLES(TMO), .ENG_RST_CYCLES(ERC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_puzzle(in_puzzle),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_puzzle(eng_puzzle),
    .eng_completed(eng_completed), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_puzzle(out_puzzle),
    .out_status(out_status), .out_passes(out_passes)
  );

  // Valid solved grid used as the source of digits.
  function automatic logic [3:0] sol_val(input int i);
    int r, c;
    r = i / 9;
    c = i % 9;
    return 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endfunction

  function automatic int count_zeros(input logic [0:W-1] g);
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (g[4*i +: 4] == 4'd0) n++;
    return n;
  endfunction

  function automatic logic [0:W-1] engine_fn(input logic [0:W-1] g, input int mode);
    logic [0:W-1] r = g;
    bit done = 1'b0;
    if (mode == M_FILL) begin
      for (int i = 0; i < CELLS; i++) begin
        if (!done && r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = sol_val(i);
          done = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [0:W-1] make_puzzle(input int nz);
    logic [0:W-1] g;
    int placed = 0;
    int p;
    for (int i = 0; i < CELLS; i++) g[4*i +: 4] = sol_val(i);
    while (placed < nz) begin
      p = $urandom_range(CELLS - 1, 0);
      if (g[4*p +: 4] != 4'd0) begin
        g[4*p +: 4] = 4'd0;
        placed++;
      end
    end
    return g;
  endfunction

  // Pass-level model: apply the engine, then judge solved / stalled / limit.
  task automatic ref_run(input logic [0:W-1] g, input int mode,
                         output logic [1:0] st, output int np, output logic [0:W-1] go);
    logic [0:W-1] cur = g;
    logic [0:W-1] r;
    bit fin = 1'b0;
    np = 0;
    st = ST_TIMEOUT;
    go = g;
    if (mode != M_NEVER) begin
      while (!fin) begin
        r = engine_fn(cur, mode);
        np++;
        fin = 1'b1;
        if (count_zeros(r) == 0)  st = ST_SOLVED;
        else if (r == cur)        st = ST_STALLED;
        else if (np == MAXP)      st = ST_PASS_LIMIT;
        else begin cur = r; fin = 1'b0; end
        go = r;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (eng_rst) begin
      eng_cnt       <= 0;
      eng_completed <= 1'b0;
    end else if (eng_start && !eng_completed) begin
      if (eng_mode != M_NEVER && eng_cnt == LAT - 1) begin
        eng_completed <= 1'b1;
        eng_result    <= engine_fn(eng_puzzle, eng_mode);
      end
      eng_cnt <= eng_cnt + 1;
    end
  end

  always @(negedge clk) begin
    prev_start <= eng_start;
    rst_run    <= eng_rst ? rst_run + 1 : 0;
    if (eng_start && !prev_start) begin
      starts <= starts + 1;
      if (rst_run < ERC) short_runs <= short_runs + 1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents a puzzle and returns once it is accepted.
  task automatic send(input logic [0:W-1] g, input string tag, output int a);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    in_puzzle = g;
    a = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int b);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20000) begin @(negedge clk); n++; end
    chk({tag, " out_valid_rise"}, out_valid, 1'b1);
    b = cyc;
  endtask

  task automatic check_result(input string tag, input logic [0:W-1] g, input int mode);
    logic [1:0] es;
    int ep;
    logic [0:W-1] eg;
    ref_run(g, mode, es, ep, eg);
    chk({tag, " status"}, out_status, es);
    chk({tag, " passes"}, out_passes, ep);
    chk({tag, " puzzle"}, out_puzzle, eg);
    $display("txn %s status=%0d passes=%0d zeros_in=%0d zeros_out=%0d", tag,
             out_status, out_passes, count_zeros(g), count_zeros(out_puzzle));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, out_valid, 1'b0);
  endtask

  task automatic run_puzzle(input logic [0:W-1] g, input int mode, input string tag);
    int a, b;
    eng_mode = mode;
    send(g, tag, a);
    wait_out(tag, b);
    check_result(tag, g, mode);
    release_out(tag);
  endtask

  initial begin
    logic [0:W-1] g, g2, held;
    int a, b, s0, nz, md, n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst eng_rst", eng_rst, 1'b1);
    chk("rst eng_start", eng_start, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_status", out_status, 2'd0);
    chk("rst out_passes", out_passes, '0);
    chk("rst out_puzzle", out_puzzle, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // 1: four empty cells, fill-one engine
    s0 = starts;
    run_puzzle(make_puzzle(4), M_FILL, "fill4");
    chk("fill4 starts", starts - s0, 4);
    chk("fill4 eng_rst_before_start", short_runs, 0);

    // 2: engine makes no progress
    run_puzzle(make_puzzle(6), M_ECHO, "echo");

    // Already-solved input still runs one pass
    run_puzzle(make_puzzle(0), M_FILL, "solved_in");

    // 3: engine never completes
    eng_mode = M_NEVER;
    g = make_puzzle(3);
    send(g, "timeout", a);
    wait_out("timeout", b);
    checks++;
    assert ((b - a) >= TMO + ERC + 1 && (b - a) <= TMO + ERC + 2) else begin
      failures++;
      $error("FAIL timeout latency observed=%0d expected=%0d..%0d", b - a, TMO + ERC + 1, TMO + ERC + 2);
    end
    chk("timeout eng_start", eng_start, 1'b0);
    chk("timeout eng_rst", eng_rst, 1'b1);
    check_result("timeout", g, M_NEVER);
    release_out("timeout");

    // 4: more empties than passes allow
    run_puzzle(make_puzzle(MAXP + 1), M_FILL, "pass_limit");
    chk("pass_limit zeros_left", count_zeros(out_puzzle), 1);

    // 5: consumer stalls in DONE while a new puzzle waits
    eng_mode = M_FILL;
    g = make_puzzle(2);
    send(g, "hold", a);
    wait_out("hold", b);
    held = out_puzzle;
    check_result("hold", g, M_FILL);
    g2 = make_puzzle(3);
    in_valid  = 1'b1;
    in_puzzle = g2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold out_valid", out_valid, 1'b1);
      chk("hold out_puzzle", out_puzzle, held);
      chk("hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release out_valid", out_valid, 1'b0);
    chk("hold release in_ready", in_ready, 1'b1);
    a = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out("after_hold", b);
    check_result("after_hold", g2, M_FILL);
    release_out("after_hold");

    // 6: reset pulled mid-RUN
    eng_mode = M_FILL;
    send(make_puzzle(5), "abort", a);
    n = 0;
    while (!eng_start && n < 100) begin @(negedge clk); n++; end
    chk("abort reached_run", eng_start, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort eng_rst", eng_rst, 1'b1);
    chk("abort eng_start", eng_start, 1'b0);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort no_result", out_valid, 1'b0);
    run_puzzle(make_puzzle(3), M_FILL, "post_abort");

    // Randomised puzzles and engine behaviour
    for (int k = 0; k < 4; k++) begin
      nz = $urandom_range(12, 1);
      md = $urandom_range(1, 0);
      run_puzzle(make_puzzle(nz), md, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "bench time limit reached");
  end

endmodule
